// File: rtl/tag_free_list_if.sv
// tag_free_list_if: issue and release handshakes between the tag free list and its clients
interface tag_free_list_if #(parameter int tag_w = 6);
  logic             pool_available;
  logic             pool_enable;
  logic [tag_w-1:0] pool_tag;
  logic             rel0_valid;
  logic             rel0_ready;
  logic [tag_w-1:0] rel0_tag;
  logic             rel1_valid;
  logic             rel1_ready;
  logic [tag_w-1:0] rel1_tag;
  modport master (
    input  pool_available, pool_tag, rel0_ready, rel1_ready,
    output pool_enable, rel0_valid, rel0_tag, rel1_valid, rel1_tag
  );
  modport slave (
    output pool_available, pool_tag, rel0_ready, rel1_ready,
    input  pool_enable, rel0_valid, rel0_tag, rel1_valid, rel1_tag
  );
endinterface

// File: rtl/tag_free_list.sv
// tag_free_list: circular free list of rename tags 1..2**tag_w-1 with round-robin release arbitration
module tag_free_list #(
  parameter int tag_w = 6,
  parameter int depth = 2**tag_w-1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  tag_free_list_if.slave   bus,
  output logic [tag_w-1:0] free_count,
  output logic             err
);
  typedef enum logic {INIT, RUN} state_t;
  localparam logic [tag_w-1:0] last = tag_w'(depth-1);
  localparam logic [tag_w-1:0] full = tag_w'(depth);
  state_t           state_q, state_d;
  logic [tag_w-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [tag_w-1:0] count_q, count_d, init_tag_q, init_tag_d;
  logic             rr_prio_q, rr_prio_d, err_q, err_d;
  logic [tag_w-1:0] mem_q [depth];
  logic             run, pop, space, g0, g1, acc, push, we;
  logic [tag_w-1:0] push_tag, wdata;

  function automatic logic [tag_w-1:0] inc(input logic [tag_w-1:0] p);
    return (p == last) ? '0 : p + 1'b1;
  endfunction

  // handshake decode, arbitration and next-state for pointers, count, priority and error
  always_comb begin
    run                = (state_q == RUN) && !flush;
    bus.pool_available = (state_q == RUN) && (count_q != '0);
    bus.pool_tag       = bus.pool_available ? mem_q[rd_ptr_q] : '0;
    pop                = run && bus.pool_enable && bus.pool_available;
    space              = (count_q != full) || pop;
    g0                 = run && bus.rel0_valid && (!bus.rel1_valid || !rr_prio_q);
    g1                 = run && bus.rel1_valid && (!bus.rel0_valid || rr_prio_q);
    bus.rel0_ready     = g0 && space;
    bus.rel1_ready     = g1 && space;
    acc                = bus.rel0_ready || bus.rel1_ready;
    push_tag           = bus.rel1_ready ? bus.rel1_tag : bus.rel0_tag;
    push               = acc && (push_tag != '0);
    state_d            = state_q;
    rd_ptr_d           = rd_ptr_q;
    wr_ptr_d           = wr_ptr_q;
    count_d            = count_q;
    init_tag_d         = init_tag_q;
    rr_prio_d          = rr_prio_q;
    err_d              = err_q;
    we                 = 1'b0;
    wdata              = push_tag;
    if (flush) begin
      state_d    = INIT;
      rd_ptr_d   = '0;
      wr_ptr_d   = '0;
      count_d    = '0;
      init_tag_d = tag_w'(1);
    end else if (state_q == INIT) begin
      we         = 1'b1;
      wdata      = init_tag_q;
      wr_ptr_d   = inc(wr_ptr_q);
      count_d    = count_q + 1'b1;
      init_tag_d = init_tag_q + 1'b1;
      state_d    = (init_tag_q == full) ? RUN : INIT;
    end else begin
      we        = push;
      rd_ptr_d  = pop ? inc(rd_ptr_q) : rd_ptr_q;
      wr_ptr_d  = push ? inc(wr_ptr_q) : wr_ptr_q;
      count_d   = count_q + tag_w'(push) - tag_w'(pop);
      rr_prio_d = acc ? !bus.rel1_ready : rr_prio_q;
      err_d     = err_q || (bus.pool_enable && !bus.pool_available)
                        || (acc && push_tag == '0) || ((g0 || g1) && !space);
    end
  end

  // control registers, cleared asynchronously
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= INIT;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
      init_tag_q <= tag_w'(1);
      rr_prio_q  <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
      init_tag_q <= init_tag_d;
      rr_prio_q  <= rr_prio_d;
      err_q      <= err_d;
    end
  end

  // tag storage; contents are rebuilt by INIT so it needs no reset
  always_ff @(posedge clk) begin
    if (we) mem_q[wr_ptr_q] <= wdata;
  end

  assign free_count = count_q;
  assign err        = err_q;
endmodule

// File: doc/tag_free_list.md
Name: tag_free_list

Overview:
- Owns the pool of free rename tags.
- Hands out one fresh tag per cycle to the tag issuer through the pool issue handshake (Available/Enable/Tag).
- Reclaims tags from two release requesters (writeback and retire), arbitrated round-robin into a single write port.
- Sits between the issue stage and the commit/writeback return paths. Sequences its own initialisation and reinitialises on pipeline flush.

Parameters:
- tag_w, 6, tag width. Tag 0 is reserved as the null tag and is never issued.
- depth, 2**tag_w-1, free-list capacity; always holds tags 1..2**tag_w-1.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- flush  in  1  pipeline flush; rebuilds the free list
- pool_available  out  1  a free tag is at the head
- pool_enable  in  1  issuer pops the head tag this cycle
- pool_tag  out  tag_w  head tag; valid while pool_available=1
- rel0_valid  in  1  release port 0 (writeback) request
- rel0_ready  out  1  release port 0 accepted
- rel0_tag  in  tag_w  tag returned on port 0
- rel1_valid  in  1  release port 1 (retire) request
- rel1_ready  out  1  release port 1 accepted
- rel1_tag  in  tag_w  tag returned on port 1
- free_count  out  tag_w  number of tags currently in the list
- err  out  1  sticky error flag; cleared only by rst

Behaviour:
- Storage: circular buffer of depth entries with rd_ptr, wr_ptr and count registers.
  - Pointers wrap from depth-1 to 0; depth is not a power of two, so wrap is explicit.
- Reset (async): state=INIT, rd_ptr=wr_ptr=0, count=0, init_tag=1, rr_prio=0, err=0.
  - All outputs are 0 during reset: pool_available, pool_tag, rel*_ready, free_count, err.
- State machine:
  - INIT:
    - Each cycle write init_tag at wr_ptr, then increment wr_ptr, count and init_tag.
    - pool_available=0 and rel*_ready=0 throughout; pool_enable is ignored.
    - After writing tag depth, go to RUN. INIT lasts exactly depth cycles (63 for tag_w=6).
  - RUN: normal operation, as below.
  - flush=1 in any state: next cycle state=INIT, with pointers, count and init_tag reset as for rst.
    - rr_prio and err are retained.
    - In the flush cycle rel*_ready=0 and pops are ignored. Nothing is written or popped in that cycle.
- Issue side (RUN only):
  - pool_available = (count!=0).
  - pool_tag = entry[rd_ptr], combinational from the registered pointer.
  - pool_enable & pool_available: rd_ptr advances, count decrements, and the next tag is visible the following cycle.
  - pool_enable while pool_available=0: no state change, err<=1.
- Release side (RUN only):
  - Single write per cycle.
  - Ready is gated by space: space = (count!=depth) | pop_this_cycle.
  - Only one port may see ready=1 in a cycle.
  - Both valid: grant the port selected by rr_prio (0→port 0, 1→port 1).
  - One valid: grant that port.
  - After an accepted grant, rr_prio <= ~granted_port.
  - rel*_ready is combinational from valid, rr_prio and space. Requesters hold valid and tag until ready.
- Simultaneous pop and push: both happen; count is unchanged.
  - A pushed tag is not bypassed to pool_tag. With count=0, a released tag becomes available on the next cycle.
- Released tag 0: accepted (ready=1) but not written, and err<=1.
- Release with count=depth and no pop (double free): not accepted, and err<=1 while valid is held.
- free_count = count (registered).

Test Plan:
- Reset then idle:
  - free_count counts 1..63 over 63 cycles while pool_available=0.
  - Cycle 64: pool_available=1, pool_tag=1, free_count=63.
- Hold pool_enable for 3 cycles after init:
  - Tags issued 1, 2, 3; free_count=60; next pool_tag=4.
- Pop all 63 tags:
  - pool_available=0.
  - Then release tag 5 on port 0: rel0_ready=1 the same cycle; next cycle pool_available=1, pool_tag=5.
- From empty, both ports valid (port0 tag 7, port1 tag 9) and held for 2 cycles:
  - Accepted in order 7 then 9 (rr_prio=0 at start).
  - Repeat with port0 tag 11 and port1 tag 12: order is 11, 12 (priority back at 0).
- After popping 10 tags, assert flush for 1 cycle:
  - rel*_ready=0 in the flush cycle.
  - 63-cycle INIT follows; afterwards pool_tag=1 and free_count=63.
- Error cases, each causes err=1 sticky until rst:
  - Release tag 0 in RUN.
  - pool_enable with the list empty.
  - Release with the list full: rel0_ready stays 0.
